stack_access_ctrl: RTL and testbench

Sequences push/pop requests from the control unit into stack memory transactions and drives the SP register's write port. It reads the current SP and computes the target address, checks stack bounds, and handshakes with data memory. On success it pulses an SP write carrying the updated pointer. It sits between the control FSM, data memory and the SP register, and consumes that register's value.

---
 rtl/stack_pkg.sv | 11 +
 rtl/stack_bound_check.sv | 21 ++
 rtl/stack_access_ctrl.sv | 100 ++++++++++
 tb/tb_stack_access_ctrl.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/stack_pkg.sv
// stack_pkg: op, state and response-code encodings shared by the stack access controller.
package stack_pkg;
    typedef enum logic {OP_PUSH = 1'b0, OP_POP = 1'b1} op_e;
    typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2} state_e;
    typedef enum logic [1:0] {
        ERR_OK  = 2'b00,
        ERR_OVF = 2'b01,
        ERR_UNF = 2'b10,
        ERR_TMO = 2'b11
    } err_e;
endpackage

// File: rtl/stack_bound_check.sv
// stack_bound_check: target address, next SP and bound error for a push/pop at the given SP.
module stack_bound_check
    import stack_pkg::*;
#(
    parameter int ADDR_W   = 16,
    parameter int SP_LIMIT = 768,
    parameter int SP_RESET = 1016
) (
    input  op_e               op,
    input  logic [ADDR_W-1:0] sp,
    output logic [ADDR_W-1:0] addr,
    output logic [ADDR_W-1:0] next_sp,
    output err_e              err
);
    always_comb begin
        addr    = op == OP_PUSH ? sp - 1'b1 : sp;
        next_sp = op == OP_PUSH ? sp - 1'b1 : sp + 1'b1;
        err     = op == OP_PUSH ? (sp <= ADDR_W'(SP_LIMIT) ? ERR_OVF : ERR_OK)
                                : (sp >= ADDR_W'(SP_RESET) ? ERR_UNF : ERR_OK);
    end
endmodule

// File: rtl/stack_access_ctrl.sv
// stack_access_ctrl: sequences push/pop commands into stack memory accesses and SP updates.
// Optional ACCESS-state timeout is enabled by defining STACK_TIMEOUT_EN.
module stack_access_ctrl
    import stack_pkg::*;
#(
    parameter int DATA_W         = 16,
    parameter int ADDR_W         = 16,
    parameter int SP_RESET       = 1016,
    parameter int SP_LIMIT       = 768,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_op,
    input  logic [DATA_W-1:0] cmd_data,
    input  logic [ADDR_W-1:0] sp_in,
    output logic              sp_write,
    output logic [ADDR_W-1:0] sp_wdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic [1:0]        rsp_err
);
    state_e            state, state_nx;
    err_e              chk_err, err_q;
    logic [ADDR_W-1:0] tgt_addr, tgt_sp;
    logic              accept, finish, tmo;

    stack_bound_check #(
        .ADDR_W  (ADDR_W),
        .SP_LIMIT(SP_LIMIT),
        .SP_RESET(SP_RESET)
    ) u_bound (
        .op     (op_e'(cmd_op)),
        .sp     (sp_in),
        .addr   (tgt_addr),
        .next_sp(tgt_sp),
        .err    (chk_err)
    );

    assign cmd_ready = state == IDLE;
    assign accept    = cmd_ready && cmd_valid;
    assign finish    = state == ACCESS && (mem_ack || tmo);
    assign mem_req   = state == ACCESS;
    assign rsp_valid = state == DONE;
    assign sp_write  = state == DONE && err_q == ERR_OK;
    assign rsp_err   = err_q;

`ifdef STACK_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] cnt;
    // Counts ACCESS cycles without an ack; an ack in the expiring cycle still wins via finish.
    assign tmo = state == ACCESS && cnt == TW'(TIMEOUT_CYCLES - 1);
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cnt <= '0;
        else        cnt <= state == ACCESS && !mem_ack && !tmo ? cnt + 1'b1 : '0;
    end
`else
    assign tmo = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        state_nx = state == IDLE   ? (accept ? (chk_err == ERR_OK ? ACCESS : DONE) : IDLE) :
                   state == ACCESS ? (finish ? DONE : ACCESS) : IDLE;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            sp_wdata  <= '0;
            rsp_data  <= '0;
            err_q     <= ERR_OK;
        end else if (accept) begin
            mem_we    <= ~cmd_op;
            mem_addr  <= tgt_addr;
            mem_wdata <= cmd_data;
            sp_wdata  <= tgt_sp;
            rsp_data  <= '0;
            err_q     <= chk_err;
        end else if (finish) begin
            if (mem_ack && !mem_we) rsp_data <= mem_rdata;
            if (!mem_ack) err_q <= ERR_TMO;
        end
    end
endmodule

// File: tb/tb_stack_access_ctrl.sv
// tb_stack_access_ctrl: directed and randomized checks of stack_access_ctrl against a queue-based stack model.
module tb_stack_access_ctrl;
    import stack_pkg::*;
    localparam int SPR = 1016;
    localparam int SPL = 768;
    localparam int CAP = SPR - SPL;

    logic clk = 0, reset = 0, cmd_valid = 0, cmd_op = 0, mem_ack = 0;
    logic [15:0] cmd_data = 0, sp_in = 16'(SPR), mem_rdata = 0;
    logic cmd_ready, sp_write, mem_req, mem_we, rsp_valid;
    logic [15:0] sp_wdata, mem_addr, mem_wdata, rsp_data;
    logic [1:0] rsp_err;
    int checks = 0, failures = 0;

    logic [15:0] sp = 16'(SPR);
    logic [15:0] mem [int];
    logic [15:0] stk [$];

    int o_rsp_cyc;
    logic [1:0] o_err;
    logic [15:0] o_data, o_spw_data, o_addr, o_wdata;
    logic o_spw, o_req, o_we, o_unstable, o_stray, o_ready;

    stack_access_ctrl #(
        .DATA_W(16), .ADDR_W(16), .SP_RESET(SPR), .SP_LIMIT(SPL), .TIMEOUT_CYCLES(4)
    ) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_data(cmd_data), .sp_in(sp_in), .sp_write(sp_write),
        .sp_wdata(sp_wdata), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    // Issues one command in an IDLE cycle, plays the memory (ack after wait_n request cycles, never if < 0)
    // and records what the DUT did; returns one cycle after the response, which should be IDLE again.
    task automatic run_cmd(input logic op, input logic [15:0] data, input int wait_n);
        int cyc = 0, reqs = 0;
        o_rsp_cyc = -1; o_req = 0; o_spw = 0; o_unstable = 0; o_stray = 0;
        o_err = 0; o_data = 0; o_spw_data = 0; o_addr = 0; o_we = 0; o_wdata = 0;
        sp_in = sp; cmd_valid = 1; cmd_op = op; cmd_data = data;
        @(posedge clk); #1;
        cmd_valid = 0; cmd_data = 16'($urandom);
        while (cyc < 40) begin
            cyc++;
            if (rsp_valid) begin
                o_rsp_cyc = cyc; o_err = rsp_err; o_data = rsp_data;
                o_spw = sp_write; o_spw_data = sp_wdata;
                break;
            end
            if (sp_write) o_stray = 1;
            mem_ack = 0;
            if (mem_req) begin
                if (!o_req) begin
                    o_req = 1; o_addr = mem_addr; o_we = mem_we; o_wdata = mem_wdata;
                end else if (mem_addr !== o_addr || mem_we !== o_we || mem_wdata !== o_wdata) o_unstable = 1;
                if (wait_n >= 0 && reqs >= wait_n) begin
                    mem_ack = 1;
                    mem_rdata = mem.exists(int'(mem_addr)) ? mem[int'(mem_addr)] : 16'h0;
                    if (mem_we) mem[int'(mem_addr)] = mem_wdata;
                end
                reqs++;
            end
            @(posedge clk); #1;
        end
        mem_ack = 0; mem_rdata = 16'($urandom);
        if (o_spw) sp = o_spw_data;
        @(posedge clk); #1;
        o_ready = cmd_ready;
    endtask

    task automatic test_reset;
        #2;
        checks++;
        if ({mem_req, mem_we, sp_write, rsp_valid} !== 4'b0 || mem_addr !== 0 || mem_wdata !== 0 ||
            sp_wdata !== 0 || rsp_data !== 0 || rsp_err !== 0) begin
            failures++;
            $display("FAIL reset_outputs req=%b we=%b spw=%b rv=%b addr=%h wd=%h spwd=%h rd=%h err=%b exp all 0",
                     mem_req, mem_we, sp_write, rsp_valid, mem_addr, mem_wdata, sp_wdata, rsp_data, rsp_err);
        end
        checks++;
        if (cmd_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", cmd_ready); end
        @(posedge clk); #3 reset = 1;
        @(posedge clk); #1;
    endtask

    task automatic test_push_wait;
        sp = 16'(SPR);
        run_cmd(1'b0, 16'hBEEF, 2);
        checks++;
        if (!o_req || o_addr !== 16'd1015 || o_we !== 1'b1 || o_wdata !== 16'hBEEF || o_unstable) begin
            failures++;
            $display("FAIL push_mem req=%b addr=%0d we=%b wdata=%h unstable=%b exp 1/1015/1/beef/0", o_req, o_addr, o_we, o_wdata, o_unstable);
        end
        checks++;
        if (o_rsp_cyc != 4 || o_err !== 2'b00 || o_data !== 16'h0) begin
            failures++;
            $display("FAIL push_rsp cyc=%0d err=%b data=%h exp 4/00/0000", o_rsp_cyc, o_err, o_data);
        end
        checks++;
        if (o_spw !== 1'b1 || o_spw_data !== 16'd1015 || o_stray) begin
            failures++;
            $display("FAIL push_spw spw=%b sp_wdata=%0d stray=%b exp 1/1015/0", o_spw, o_spw_data, o_stray);
        end
        checks++;
        if (o_ready !== 1'b1) begin failures++; $display("FAIL push_ready_after got=%b exp=1", o_ready); end
    endtask

    task automatic test_pop_zero_wait;
        sp = 16'd1015;
        mem[1015] = 16'h1234;
        run_cmd(1'b1, 16'($urandom), 0);
        checks++;
        if (!o_req || o_addr !== 16'd1015 || o_we !== 1'b0) begin
            failures++;
            $display("FAIL pop_mem req=%b addr=%0d we=%b exp 1/1015/0", o_req, o_addr, o_we);
        end
        checks++;
        if (o_rsp_cyc != 2 || o_err !== 2'b00 || o_data !== 16'h1234) begin
            failures++;
            $display("FAIL pop_rsp cyc=%0d err=%b data=%h exp 2/00/1234", o_rsp_cyc, o_err, o_data);
        end
        checks++;
        if (o_spw !== 1'b1 || o_spw_data !== 16'd1016) begin
            failures++;
            $display("FAIL pop_spw spw=%b sp_wdata=%0d exp 1/1016", o_spw, o_spw_data);
        end
    endtask

    task automatic test_bounds;
        sp = 16'(SPR);
        run_cmd(1'b1, 16'h0, 0);
        checks++;
        if (o_rsp_cyc != 1 || o_err !== 2'b10 || o_req || o_spw !== 1'b0 || o_stray || o_data !== 0) begin
            failures++;
            $display("FAIL underflow cyc=%0d err=%b req=%b spw=%b data=%h exp 1/10/0/0/0", o_rsp_cyc, o_err, o_req, o_spw, o_data);
        end
        checks++;
        if (o_ready !== 1'b1) begin failures++; $display("FAIL underflow_ready got=%b exp=1", o_ready); end
        sp = 16'(SPL);
        run_cmd(1'b0, 16'hA5A5, 0);
        checks++;
        if (o_rsp_cyc != 1 || o_err !== 2'b01 || o_req || o_spw !== 1'b0 || o_stray) begin
            failures++;
            $display("FAIL overflow cyc=%0d err=%b req=%b spw=%b exp 1/01/0/0", o_rsp_cyc, o_err, o_req, o_spw);
        end
        sp = 16'(SPL + 1);
        run_cmd(1'b0, 16'h5A5A, 1);
        checks++;
        if (o_err !== 2'b00 || o_addr !== 16'(SPL) || o_spw_data !== 16'(SPL) || o_rsp_cyc != 3) begin
            failures++;
            $display("FAIL push_to_limit err=%b addr=%0d sp_wdata=%0d cyc=%0d exp 00/%0d/%0d/3", o_err, o_addr, o_spw_data, o_rsp_cyc, SPL, SPL);
        end
    endtask

    task automatic test_reset_mid_access;
        sp = 16'(SPR);
        sp_in = sp; cmd_valid = 1; cmd_op = 0; cmd_data = 16'hCAFE;
        @(posedge clk); #1 cmd_valid = 0;
        @(posedge clk); #1;
        checks++;
        if (mem_req !== 1'b1) begin failures++; $display("FAIL mid_req_before_reset got=%b exp=1", mem_req); end
        #2 reset = 0;
        #1;
        checks++;
        if ({mem_req, mem_we, sp_write, rsp_valid} !== 4'b0 || mem_addr !== 0 || mem_wdata !== 0 ||
            sp_wdata !== 0 || rsp_data !== 0 || rsp_err !== 0 || cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL mid_reset_outputs req=%b we=%b addr=%h wd=%h rdy=%b exp 0/0/0/0/1", mem_req, mem_we, mem_addr, mem_wdata, cmd_ready);
        end
        @(posedge clk); #3 reset = 1;
        @(posedge clk); #1 mem_ack = 1;
        @(posedge clk); #1 mem_ack = 0;
        checks++;
        if (rsp_valid !== 1'b0 || sp_write !== 1'b0 || mem_req !== 1'b0 || cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL stray_ack rv=%b spw=%b req=%b rdy=%b exp 0/0/0/1", rsp_valid, sp_write, mem_req, cmd_ready);
        end
        run_cmd(1'b0, 16'h7777, 1);
        checks++;
        if (o_err !== 2'b00 || o_addr !== 16'd1015 || o_wdata !== 16'h7777 || o_spw_data !== 16'd1015 || o_rsp_cyc != 3) begin
            failures++;
            $display("FAIL push_after_reset err=%b addr=%0d wd=%h sp_wdata=%0d cyc=%0d exp 00/1015/7777/1015/3", o_err, o_addr, o_wdata, o_spw_data, o_rsp_cyc);
        end
    endtask

`ifdef STACK_TIMEOUT_EN
    task automatic test_timeout;
        sp = 16'(SPR);
        run_cmd(1'b0, 16'h1111, -1);
        checks++;
        if (!o_req || o_rsp_cyc != 5 || o_err !== 2'b11 || o_spw !== 1'b0 || o_stray) begin
            failures++;
            $display("FAIL timeout req=%b cyc=%0d err=%b spw=%b exp 1/5/11/0", o_req, o_rsp_cyc, o_err, o_spw);
        end
        run_cmd(1'b0, 16'h2222, 3);
        checks++;
        if (o_rsp_cyc != 5 || o_err !== 2'b00 || o_spw !== 1'b1 || o_spw_data !== 16'd1015) begin
            failures++;
            $display("FAIL ack_at_timeout cyc=%0d err=%b spw=%b sp_wdata=%0d exp 5/00/1/1015", o_rsp_cyc, o_err, o_spw, o_spw_data);
        end
    endtask
`endif

    // Stack model: a queue of pushed words; depth alone decides bounds, address and new SP.
    task automatic random_ops(input int n, input int push_pct);
        for (int i = 0; i < n; i++) begin
            logic op;
            logic [15:0] d, exp_data, exp_sp;
            logic [1:0] exp_err;
            int w, depth;
            op = ($urandom_range(99) >= push_pct);
            d = 16'($urandom);
            w = $urandom_range(3);
            depth = stk.size();
            exp_data = 0; exp_sp = 0;
            if (op == 0) begin
                exp_err = depth == CAP ? 2'b01 : 2'b00;
                exp_sp = 16'(SPR - depth - 1);
                if (exp_err == 2'b00) stk.push_back(d);
            end else begin
                exp_err = depth == 0 ? 2'b10 : 2'b00;
                exp_sp = 16'(SPR - depth + 1);
                if (exp_err == 2'b00) exp_data = stk.pop_back();
            end
            run_cmd(op, d, w);
            checks++;
            if (o_err !== exp_err || o_data !== exp_data || o_rsp_cyc != (exp_err == 0 ? w + 2 : 1)) begin
                failures++;
                $display("FAIL rand_rsp[%0d] op=%b err=%b data=%h cyc=%0d exp %b/%h/%0d", i, op, o_err, o_data, o_rsp_cyc,
                         exp_err, exp_data, exp_err == 0 ? w + 2 : 1);
            end
            checks++;
            if (o_spw !== (exp_err == 0) || o_req !== (exp_err == 0) || o_unstable || o_stray ||
                (exp_err == 0 && (o_spw_data !== exp_sp || o_addr !== (op ? exp_sp - 16'd1 : exp_sp) || o_we !== ~op))) begin
                failures++;
                $display("FAIL rand_side[%0d] op=%b spw=%b sp_wdata=%0d req=%b addr=%0d we=%b exp sp=%0d", i, op, o_spw, o_spw_data,
                         o_req, o_addr, o_we, exp_sp);
            end
        end
    endtask

    task automatic test_random;
        sp = 16'(SPR);
        stk.delete();
        mem.delete();
        random_ops(50, 55);
        sp = 16'(SPR - (CAP - 2));
        stk.delete();
        for (int i = 0; i < CAP - 2; i++) begin
            logic [15:0] v;
            v = 16'($urandom);
            stk.push_back(v);
            mem[SPR - 1 - i] = v;
        end
        random_ops(25, 75);
    endtask

    initial begin
        test_reset();
        test_push_wait();
        test_pop_zero_wait();
        test_bounds();
        test_reset_mid_access();
`ifdef STACK_TIMEOUT_EN
        test_timeout();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
